// File: rtl/mul_add_pipe_if.sv
// mul_add_pipe_if
// Groups the streaming handshake and data signals of mul_add_pipe.
//   Input side : in_valid, in_ready, A, B, C, mode, in_last
//   Output side: out_valid, out_ready, DATA_OUT, out_ovf
// Modports:
//   master - the environment. It drives operands and out_ready,
//            and it observes in_ready and the result.
//   slave  - the datapath. It accepts operands and drives the result.
interface mul_add_pipe_if #(
    parameter int S = 8,
    parameter int G = 4
);
    localparam int W = 2 * S + G;

    logic         in_valid;
    logic         in_ready;
    logic [S-1:0] A;
    logic [S-1:0] B;
    logic [S-1:0] C;
    logic [1:0]   mode;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] DATA_OUT;
    logic         out_ovf;

    modport master (
        output in_valid, A, B, C, mode, in_last, out_ready,
        input  in_ready, out_valid, DATA_OUT, out_ovf
    );

    modport slave (
        input  in_valid, A, B, C, mode, in_last, out_ready,
        output in_ready, out_valid, DATA_OUT, out_ovf
    );
endinterface

// File: rtl/mul_add_pipe.sv
// mul_add_pipe
// Two-register streaming multiply-add / accumulate datapath.
// The block computes A*B+C, passes C through, or accumulates A*B products across a burst.
// All sums are W = 2*S+G bits wide and wrap modulo 2^W. The flag out_ovf reports any wrap.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - mul_add_pipe_if.slave. It carries the in_valid/in_ready operand channel
//           (A, B, C, mode, in_last) and the out_valid/out_ready result channel
//           (DATA_OUT, out_ovf).
module mul_add_pipe #(
    parameter int S = 8,
    parameter int G = 4
) (
    input logic          clk,
    input logic          reset,
    mul_add_pipe_if.slave bus
);
    localparam int W = 2 * S + G;

    localparam logic [1:0] MODE_MULADD   = 2'b00;
    localparam logic [1:0] MODE_ACC      = 2'b01;
    localparam logic [1:0] MODE_ACC_INIT = 2'b10;
    localparam logic [1:0] MODE_PASS     = 2'b11;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    logic           en;
    logic           accept;
    logic [2*S-1:0] product;

    logic           s1_valid;
    logic [2*S-1:0] s1_p;
    logic [S-1:0]   s1_c;
    logic [1:0]     s1_mode;
    logic           s1_last;

    logic [0:0]     state;
    logic [W-1:0]   acc;
    logic           ovf_acc;

    logic [W-1:0]   data_q;
    logic           out_valid_q;
    logic           out_ovf_q;

    logic [W-1:0]   p_ext;
    logic [W-1:0]   c_ext;
    logic [W-1:0]   acc_base;
    logic           ovf_prior;
    logic [W:0]     sum_full;

    // The whole pipeline stalls only when a result is waiting and the sink refuses it.
    assign en          = !(out_valid_q && !bus.out_ready);
    assign accept      = bus.in_valid && en;
    assign product     = {{S{1'b0}}, bus.A} * {{S{1'b0}}, bus.B};

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.DATA_OUT  = data_q;
    assign bus.out_ovf   = out_ovf_q;

    // ACC_INIT restarts the burst from C and drops any prior overflow.
    // ACC continues the open burst, or starts from zero when no burst is active.
    always_comb begin
        p_ext     = {{G{1'b0}}, s1_p};
        c_ext     = {{(W-S){1'b0}}, s1_c};
        acc_base  = (state == ACCUM) ? acc : '0;
        ovf_prior = ovf_acc;
        if (s1_mode == MODE_ACC_INIT) begin
            acc_base  = c_ext;
            ovf_prior = 1'b0;
        end
        sum_full = {1'b0, acc_base} + {1'b0, p_ext};
    end

    // Stage 1 captures the product and control fields of each accepted beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_c     <= '0;
            s1_mode  <= MODE_MULADD;
            s1_last  <= 1'b0;
        end else if (en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_p    <= product;
                s1_c    <= bus.C;
                s1_mode <= bus.mode;
                s1_last <= bus.in_last;
            end
        end
    end

    // Stage 2 computes the result and updates the accumulator and burst FSM.
    // A non-last accumulate beat updates internal state only and produces no result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q      <= '0;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            acc         <= '0;
            ovf_acc     <= 1'b0;
            state       <= IDLE;
        end else if (en) begin
            out_valid_q <= 1'b0;
            if (s1_valid) begin
                case (s1_mode)
                    MODE_MULADD: begin
                        data_q      <= p_ext + c_ext;
                        out_valid_q <= 1'b1;
                        out_ovf_q   <= 1'b0;
                    end
                    MODE_PASS: begin
                        data_q      <= c_ext;
                        out_valid_q <= 1'b1;
                        out_ovf_q   <= 1'b0;
                    end
                    default: begin
                        if (s1_last) begin
                            data_q      <= sum_full[W-1:0];
                            out_ovf_q   <= ovf_prior | sum_full[W];
                            out_valid_q <= 1'b1;
                            acc         <= '0;
                            ovf_acc     <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            acc     <= sum_full[W-1:0];
                            ovf_acc <= ovf_prior | sum_full[W];
                            state   <= ACCUM;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mul_add_pipe.sv
// tb_mul_add_pipe
// Directed testbench for mul_add_pipe with S=8 and G=4, so W=20.
// Each scenario task drives its own beats and compares the DUT outputs
// with values computed by hand.
module tb_mul_add_pipe;
    localparam logic [1:0] MULADD   = 2'b00;
    localparam logic [1:0] ACC      = 2'b01;
    localparam logic [1:0] ACC_INIT = 2'b10;
    localparam logic [1:0] PASS     = 2'b11;

    logic clk;
    logic reset;
    int   checks;
    int   passed;

    mul_add_pipe_if #(.S(8), .G(4)) bus ();

    mul_add_pipe #(.S(8), .G(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one cycle of input, then advances to 1 time unit after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] c, input logic [1:0] m, input logic last);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.C        = c;
        bus.mode     = m;
        bus.in_last  = last;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, MULADD, 1'b0);
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.A          = '0;
        bus.B          = '0;
        bus.C          = '0;
        bus.mode       = MULADD;
        bus.in_last    = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.DATA_OUT !== 20'd0 || bus.out_ovf !== 1'b0 || bus.in_ready !== 1'b1)
            $display("[TB] FAIL reset_state: got valid=%b data=%0d ovf=%b ready=%b expected 0 0 0 1",
                     bus.out_valid, bus.DATA_OUT, bus.out_ovf, bus.in_ready);
        else passed++;
        reset = 1'b1;
        idle();
    endtask

    task automatic test_muladd();
        applyStimulus(1'b1, 8'd3, 8'd4, 8'd5, MULADD, 1'b0);
        applyStimulus(1'b1, 8'd255, 8'd255, 8'd255, MULADD, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.DATA_OUT !== 20'd17 || bus.out_ovf !== 1'b0)
            $display("[TB] FAIL muladd_17: got valid=%b data=%0d ovf=%b expected 1 17 0",
                     bus.out_valid, bus.DATA_OUT, bus.out_ovf);
        else passed++;
        applyStimulus(1'b1, 8'd7, 8'd7, 8'd9, PASS, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.DATA_OUT !== 20'd65280 || bus.out_ovf !== 1'b0)
            $display("[TB] FAIL muladd_max: got valid=%b data=%0d ovf=%b expected 1 65280 0",
                     bus.out_valid, bus.DATA_OUT, bus.out_ovf);
        else passed++;
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.DATA_OUT !== 20'd9 || bus.out_ovf !== 1'b0)
            $display("[TB] FAIL pass_9: got valid=%b data=%0d ovf=%b expected 1 9 0",
                     bus.out_valid, bus.DATA_OUT, bus.out_ovf);
        else passed++;
        idle();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.DATA_OUT !== 20'd9)
            $display("[TB] FAIL idle_hold: got valid=%b data=%0d expected 0 9",
                     bus.out_valid, bus.DATA_OUT);
        else passed++;
    endtask

    task automatic test_acc_burst();
        logic seen;
        seen = 1'b0;
        applyStimulus(1'b1, 8'd2, 8'd3, 8'd0, ACC, 1'b0);
        seen |= bus.out_valid;
        applyStimulus(1'b1, 8'd4, 8'd5, 8'd0, ACC, 1'b0);
        seen |= bus.out_valid;
        applyStimulus(1'b1, 8'd1, 8'd1, 8'd0, ACC, 1'b1);
        seen |= bus.out_valid;
        checks++;
        if (seen !== 1'b0)
            $display("[TB] FAIL acc_no_early_out: got out_valid seen=%b expected 0", seen);
        else passed++;
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.DATA_OUT !== 20'd27 || bus.out_ovf !== 1'b0)
            $display("[TB] FAIL acc_27: got valid=%b data=%0d ovf=%b expected 1 27 0",
                     bus.out_valid, bus.DATA_OUT, bus.out_ovf);
        else passed++;
        idle();
        checks++;
        if (bus.out_valid !== 1'b0)
            $display("[TB] FAIL acc_single_out: got valid=%b expected 0", bus.out_valid);
        else passed++;
    endtask

    task automatic test_bias_overflow();
        logic seen;
        applyStimulus(1'b1, 8'd10, 8'd10, 8'd100, ACC_INIT, 1'b1);
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.DATA_OUT !== 20'd200 || bus.out_ovf !== 1'b0)
            $display("[TB] FAIL acc_init_200: got valid=%b data=%0d ovf=%b expected 1 200 0",
                     bus.out_valid, bus.DATA_OUT, bus.out_ovf);
        else passed++;
        seen = 1'b0;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 8'd255, 8'd255, 8'd0, ACC, (i == 16));
            seen |= bus.out_valid;
        end
        checks++;
        if (seen !== 1'b0)
            $display("[TB] FAIL ovf_no_early_out: got out_valid seen=%b expected 0", seen);
        else passed++;
        idle();
        // 17 * 65025 = 1105425 and 1105425 mod 2^20 = 56849, so the sum wraps once.
        checks++;
        if (bus.out_valid !== 1'b1 || bus.DATA_OUT !== 20'd56849 || bus.out_ovf !== 1'b1)
            $display("[TB] FAIL acc_ovf: got valid=%b data=%0d ovf=%b expected 1 56849 1",
                     bus.out_valid, bus.DATA_OUT, bus.out_ovf);
        else passed++;
        applyStimulus(1'b1, 8'd1, 8'd1, 8'd0, ACC, 1'b1);
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.DATA_OUT !== 20'd1 || bus.out_ovf !== 1'b0)
            $display("[TB] FAIL ovf_cleared: got valid=%b data=%0d ovf=%b expected 1 1 0",
                     bus.out_valid, bus.DATA_OUT, bus.out_ovf);
        else passed++;
        idle();
    endtask

    task automatic test_backpressure();
        logic [19:0] expq[$];
        logic [19:0] expv;
        int sent;
        int got;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            bus.out_ready = !(cyc >= 3 && cyc < 6);
            if (sent < 6) begin
                bus.in_valid = 1'b1;
                bus.A        = 8'(sent + 1);
                bus.B        = 8'd2;
                bus.C        = 8'(sent + 1);
                bus.mode     = MULADD;
                bus.in_last  = 1'b0;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (!bus.out_ready) begin
                checks++;
                if (bus.in_ready !== 1'b0 || expq.size() == 0 || bus.DATA_OUT !== expq[0])
                    $display("[TB] FAIL stall_hold cyc%0d: got ready=%b data=%0d expected ready 0 data %0d",
                             cyc, bus.in_ready, bus.DATA_OUT, (expq.size() > 0) ? expq[0] : 20'd0);
                else passed++;
            end
            if (bus.out_valid && bus.out_ready) begin
                expv = (expq.size() > 0) ? expq.pop_front() : 20'hFFFFF;
                checks++;
                if (bus.DATA_OUT !== expv)
                    $display("[TB] FAIL stream_order: got %0d expected %0d", bus.DATA_OUT, expv);
                else passed++;
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(20'(3 * (sent + 1)));
                sent++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (got !== 6 || sent !== 6)
            $display("[TB] FAIL stream_count: got %0d results from %0d beats expected 6 from 6", got, sent);
        else passed++;
        idle();
        idle();
    endtask

    task automatic test_interleave();
        applyStimulus(1'b1, 8'd2, 8'd2, 8'd0, ACC, 1'b0);
        applyStimulus(1'b1, 8'd1, 8'd1, 8'd1, MULADD, 1'b0);
        applyStimulus(1'b1, 8'd3, 8'd3, 8'd0, ACC, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.DATA_OUT !== 20'd2)
            $display("[TB] FAIL interleave_muladd: got valid=%b data=%0d expected 1 2",
                     bus.out_valid, bus.DATA_OUT);
        else passed++;
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.DATA_OUT !== 20'd13 || bus.out_ovf !== 1'b0)
            $display("[TB] FAIL interleave_acc: got valid=%b data=%0d ovf=%b expected 1 13 0",
                     bus.out_valid, bus.DATA_OUT, bus.out_ovf);
        else passed++;
        idle();
    endtask

    task automatic test_reset_midburst();
        applyStimulus(1'b1, 8'd50, 8'd50, 8'd0, ACC, 1'b0);
        applyStimulus(1'b1, 8'd5, 8'd5, 8'd5, MULADD, 1'b0);
        idle();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.DATA_OUT !== 20'd0 || bus.out_ovf !== 1'b0 || bus.in_ready !== 1'b1)
            $display("[TB] FAIL async_reset: got valid=%b data=%0d ovf=%b ready=%b expected 0 0 0 1",
                     bus.out_valid, bus.DATA_OUT, bus.out_ovf, bus.in_ready);
        else passed++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 8'd2, 8'd2, 8'd0, ACC, 1'b1);
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.DATA_OUT !== 20'd4 || bus.out_ovf !== 1'b0)
            $display("[TB] FAIL post_reset_acc: got valid=%b data=%0d ovf=%b expected 1 4 0",
                     bus.out_valid, bus.DATA_OUT, bus.out_ovf);
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        $display("[TB] starting mul_add_pipe directed tests");
        test_reset();
        test_muladd();
        test_acc_burst();
        test_bias_overflow();
        test_backpressure();
        test_interleave();
        test_reset_midburst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
